macro_reduction_tree_pipelined: RTL

Pipelined, parametrised bitwise reduction tree that generalises the combinational AND-reduction macro. It supports selectable AND/OR/XOR operation, pads unused leaves with the correct identity element, and places registers every STAGE_INTERVAL tree levels. A valid/ready handshake with full backpressure lets the block sit on wide timing-critical reduction paths (hit-vector merge, wakeup/valid aggregation) inside any pipeline without combinational depth growing with INPUT_COUNT.

---
 rtl/macro_reduction_tree_pipelined.sv | 121 ++++++++++++
 1 files changed

// File: rtl/macro_reduction_tree_pipelined.sv
// Pipelined AND/OR/XOR reduction tree with identity-padded leaves and valid/ready flow control.
// A register stage is placed every STAGE_INTERVAL tree levels; the root is always registered.
`timescale 1ns/1ps
module macro_reduction_tree_pipelined #(
  parameter int unsigned INPUT_WIDTH    = 1,
  parameter int unsigned INPUT_COUNT    = 2,
  parameter int unsigned OP             = 0,
  parameter int unsigned STAGE_INTERVAL = 1
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [INPUT_WIDTH*INPUT_COUNT-1:0] d,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [INPUT_WIDTH-1:0]             q
);

  localparam int unsigned W  = INPUT_WIDTH;
  localparam int unsigned SI = (STAGE_INTERVAL == 0) ? 1 : STAGE_INTERVAL;
  localparam int unsigned L  = $clog2(INPUT_COUNT);
  localparam int unsigned P  = 1 << L;
  localparam int unsigned S  = (L == 0) ? 1 : (L + SI - 1) / SI;
  localparam logic [W-1:0] IDENT = (OP == 0) ? {W{1'b1}} : {W{1'b0}};

  if (OP > 2 || INPUT_COUNT < 1 || STAGE_INTERVAL < 1 || INPUT_WIDTH < 1) begin : g_cfg_err
    $error("macro_reduction_tree_pipelined: illegal parameter combination");
  end

  function automatic logic [W-1:0] op_f(input logic [W-1:0] a, input logic [W-1:0] b);
    if (OP == 0) return a & b;
    if (OP == 1) return a | b;
    return a ^ b;
  endfunction

  function automatic int unsigned min_lv(input int unsigned x);
    return (x < L) ? x : L;
  endfunction

  // Leaf vector: real lanes first, identity elements fill the power-of-two remainder
  logic [P-1:0][W-1:0] leaves;
  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < INPUT_COUNT) begin : g_lane
      assign leaves[i] = d[W*i +: W];
    end else begin : g_pad
      assign leaves[i] = IDENT;
    end
  end

  logic [S:1]   valid_r;
  logic [S:1]   up_valid;
  logic [S+1:1] stage_ready;

  // A stage accepts when empty or when its own entry leaves this cycle
  always_comb begin
    stage_ready        = '0;
    up_valid           = '0;
    stage_ready[S+1]   = out_ready;
    for (int k = int'(S); k >= 1; k--) begin
      stage_ready[k] = !valid_r[k] || stage_ready[k+1];
    end
    up_valid[1] = in_valid;
    for (int k = 2; k <= int'(S); k++) begin
      up_valid[k] = valid_r[k-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_r <= '0;
    end else if (flush) begin
      valid_r <= '0;
    end else begin
      valid_r <= (stage_ready[S:1] & up_valid) | (~stage_ready[S:1] & valid_r);
    end
  end

  for (genvar k = 1; k <= S; k++) begin : g_stage
    localparam int unsigned LV_IN  = min_lv(SI * (k - 1));
    localparam int unsigned LV_OUT = min_lv(SI * k);
    localparam int unsigned N_IN   = P >> LV_IN;
    localparam int unsigned N_OUT  = P >> LV_OUT;

    logic [N_IN-1:0][W-1:0]  stage_in;
    logic [N_IN-1:0][W-1:0]  tree;
    logic [N_OUT-1:0][W-1:0] data_r;

    if (k == 1) begin : g_src
      assign stage_in = leaves;
    end else begin : g_src
      assign stage_in = g_stage[k-1].data_r;
    end

    // In-place pairwise reduction; each level halves the live node count
    always_comb begin
      tree = stage_in;
      for (int unsigned lv = 0; lv < LV_OUT - LV_IN; lv++) begin
        for (int unsigned n = 0; n < N_IN / 2; n++) begin
          if (n < (N_IN >> (lv + 1))) begin
            tree[n] = op_f(tree[2*n], tree[2*n+1]);
          end
        end
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        data_r <= '0;
      end else if (stage_ready[k] && up_valid[k]) begin
        data_r <= tree[N_OUT-1:0];
      end
    end
  end

  assign in_ready  = stage_ready[1];
  assign out_valid = valid_r[S];
  assign q         = g_stage[S].data_r[0];

endmodule
